// File: rtl/lru_way_allocator.sv
// Set-associative way allocator: looks up a tag across NUM_WAYS ways, reports
// a hit, or allocates a way (lowest invalid first, otherwise the tracker's
// LRU way with eviction). It emits one touch strobe per response so that an
// external LRU tracker can update its recency order.
module lru_way_allocator #(
  parameter  int NUM_WAYS  = 4,
  parameter  int TAG_WIDTH = 8,
  localparam int PTR_WIDTH = $clog2(NUM_WAYS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [TAG_WIDTH-1:0] req_tag,
  input  logic                 flush,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 resp_hit,
  output logic [PTR_WIDTH-1:0] resp_way,
  output logic                 resp_evict,
  output logic [TAG_WIDTH-1:0] resp_evict_tag,
  output logic [PTR_WIDTH-1:0] access_way,
  output logic                 access_valid,
  input  logic [PTR_WIDTH-1:0] lru_way
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_RESP
  } state_e;

  state_e                               state_q, state_d;
  logic                                 ready_en_q;
  logic [TAG_WIDTH-1:0]                 lookup_tag_q, lookup_tag_d;
  logic [NUM_WAYS-1:0]                  valid_q, valid_d;
  logic [NUM_WAYS-1:0][TAG_WIDTH-1:0]   tag_q, tag_d;
  logic                                 resp_hit_q, resp_hit_d;
  logic [PTR_WIDTH-1:0]                 resp_way_q, resp_way_d;
  logic                                 resp_evict_q, resp_evict_d;
  logic [TAG_WIDTH-1:0]                 resp_evict_tag_q, resp_evict_tag_d;
  logic [PTR_WIDTH-1:0]                 access_way_q, access_way_d;
  logic                                 access_valid_q, access_valid_d;

  logic                                 hit_found;
  logic [PTR_WIDTH-1:0]                 hit_idx;
  logic                                 free_found;
  logic [PTR_WIDTH-1:0]                 free_idx;
  logic [PTR_WIDTH-1:0]                 sel_way;
  logic                                 sel_evict;

  // Priority search: scanning downwards leaves the lowest matching index.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    hit_found  = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (valid_q[i] && (tag_q[i] == lookup_tag_q)) begin
        hit_found = 1'b1;
        hit_idx   = PTR_WIDTH'(i);
      end
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = PTR_WIDTH'(i);
      end
    end
  end

  // Way choice: hit way, else lowest free way, else the tracker's LRU way.
  always_comb begin
    sel_evict = 1'b0;
    if (hit_found) begin
      sel_way = hit_idx;
    end else if (free_found) begin
      sel_way = free_idx;
    end else begin
      sel_way   = lru_way;
      sel_evict = 1'b1;
    end
  end

  // Next-state logic for the FSM, the way storage and the response registers.
  always_comb begin
    state_d          = state_q;
    lookup_tag_d     = lookup_tag_q;
    valid_d          = valid_q;
    tag_d            = tag_q;
    resp_hit_d       = resp_hit_q;
    resp_way_d       = resp_way_q;
    resp_evict_d     = resp_evict_q;
    resp_evict_tag_d = resp_evict_tag_q;
    access_way_d     = access_way_q;
    access_valid_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (flush) begin
          valid_d = '0;
        end else if (req_valid && ready_en_q) begin
          lookup_tag_d = req_tag;
          state_d      = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        state_d          = S_RESP;
        resp_hit_d       = hit_found;
        resp_way_d       = sel_way;
        resp_evict_d     = sel_evict;
        resp_evict_tag_d = sel_evict ? tag_q[sel_way] : '0;
        access_way_d     = sel_way;
        access_valid_d   = 1'b1;
        if (!hit_found) begin
          tag_d[sel_way]   = lookup_tag_q;
          valid_d[sel_way] = 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= S_IDLE;
      ready_en_q       <= 1'b0;
      lookup_tag_q     <= '0;
      valid_q          <= '0;
      // NOTE: the tag array is reset on purpose: zeroed tags are part of the visible reset state.
      tag_q            <= '0;
      resp_hit_q       <= 1'b0;
      resp_way_q       <= '0;
      resp_evict_q     <= 1'b0;
      resp_evict_tag_q <= '0;
      access_way_q     <= '0;
      access_valid_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q          <= state_d;
      ready_en_q       <= 1'b1;
      lookup_tag_q     <= lookup_tag_d;
      valid_q          <= valid_d;
      tag_q            <= tag_d;
      resp_hit_q       <= resp_hit_d;
      resp_way_q       <= resp_way_d;
      resp_evict_q     <= resp_evict_d;
      resp_evict_tag_q <= resp_evict_tag_d;
      access_way_q     <= access_way_d;
      access_valid_q   <= access_valid_d;
    end
  end

  assign req_ready      = ready_en_q && (state_q == S_IDLE) && !flush;
  assign resp_valid     = (state_q == S_RESP);
  assign resp_hit       = resp_hit_q;
  assign resp_way       = resp_way_q;
  assign resp_evict     = resp_evict_q;
  assign resp_evict_tag = resp_evict_tag_q;
  assign access_way     = access_way_q;
  assign access_valid   = access_valid_q;

endmodule

// File: tb/tb_lru_way_allocator.sv
// Bench for lru_way_allocator: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural set model with an LRU tracker.
module tb_lru_way_allocator;

  localparam int NW = 4;
  localparam int TW = 8;
  localparam int PW = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [TW-1:0] req_tag = '0;
  logic          flush = 1'b0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic          resp_hit;
  logic [PW-1:0] resp_way;
  logic          resp_evict;
  logic [TW-1:0] resp_evict_tag;
  logic [PW-1:0] access_way;
  logic          access_valid;
  logic [PW-1:0] lru_way = '0;

  lru_way_allocator #(.NUM_WAYS(NW), .TAG_WIDTH(TW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag),
    .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_hit(resp_hit), .resp_way(resp_way),
    .resp_evict(resp_evict), .resp_evict_tag(resp_evict_tag),
    .access_way(access_way), .access_valid(access_valid),
    .lru_way(lru_way)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [TW-1:0] m_tag [NW];
  bit            m_valid [NW];
  int            order[$];          // order[0] = least recently used way
  logic          exp_hit;
  int            exp_way;
  logic          exp_evict;
  logic [TW-1:0] exp_evict_tag;

  // phase: 0 idle, 1 lookup, 2 first response cycle, 3 later response cycles
  int phase = 0;
  bit ready_ok = 1'b0;
  int av_count = 0;
  logic          cap_hit;
  int            cap_way;
  logic          cap_evict;
  logic [TW-1:0] cap_evict_tag;

  task automatic model_init();
    for (int i = 0; i < NW; i++) begin
      m_tag[i]   = '0;
      m_valid[i] = 1'b0;
    end
    order.delete();
    for (int i = 0; i < NW; i++) order.push_back(i);
  endtask

  task automatic touch(input int w);
    for (int i = 0; i < order.size(); i++)
      if (order[i] == w) begin
        order.delete(i);
        break;
      end
    order.push_back(w);
  endtask

  task automatic predict(input logic [TW-1:0] t, input int lru_in);
    int hit_w, free_w;
    hit_w  = -1;
    free_w = -1;
    for (int i = 0; i < NW; i++) begin
      if (hit_w < 0 && m_valid[i] && m_tag[i] == t) hit_w = i;
      if (free_w < 0 && !m_valid[i]) free_w = i;
    end
    exp_evict     = 1'b0;
    exp_evict_tag = '0;
    if (hit_w >= 0) begin
      exp_hit = 1'b1;
      exp_way = hit_w;
    end else begin
      exp_hit = 1'b0;
      exp_way = (free_w >= 0) ? free_w : lru_in;
      if (free_w < 0) begin
        exp_evict     = 1'b1;
        exp_evict_tag = m_tag[exp_way];
      end
      m_tag[exp_way]   = t;
      m_valid[exp_way] = 1'b1;
    end
    touch(exp_way);
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!reset_n) begin
      check("rst_req_ready", req_ready, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_hit", resp_hit, 0);
      check("rst_resp_way", resp_way, 0);
      check("rst_resp_evict", resp_evict, 0);
      check("rst_resp_evict_tag", resp_evict_tag, 0);
      check("rst_access_way", access_way, 0);
      check("rst_access_valid", access_valid, 0);
    end else begin
      check("req_ready", req_ready, 32'(ready_ok && phase == 0 && !flush));
      check("resp_valid", resp_valid, 32'(phase >= 2));
      check("access_valid", access_valid, 32'(phase == 2));
      if (phase >= 2) begin
        check("resp_hit", resp_hit, exp_hit);
        check("resp_way", resp_way, exp_way);
        check("resp_evict", resp_evict, exp_evict);
        check("resp_evict_tag", resp_evict_tag, exp_evict_tag);
        cap_hit       = resp_hit;
        cap_way       = int'(resp_way);
        cap_evict     = resp_evict;
        cap_evict_tag = resp_evict_tag;
      end
      if (phase == 2) check("access_way", access_way, exp_way);
      if (access_valid) av_count++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset_n    = 1'b0;
    ready_ok   = 1'b0;
    phase      = 0;
    req_valid  = 1'b0;
    flush      = 1'b0;
    resp_ready = 1'b0;
    model_init();
    repeat (cycles) @(posedge clk);
    #1 reset_n = 1'b1;
    step();
    ready_ok = 1'b1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < NW; i++) m_valid[i] = 1'b0;
  endtask

  task automatic do_req(input logic [TW-1:0] t, input int hold, input int force_lru, input bit lk_flush);
    int lru_in;
    lru_in  = (force_lru >= 0) ? force_lru : order[0];
    lru_way = PW'(lru_in);
    predict(t, lru_in);
    req_valid = 1'b1;
    req_tag   = t;
    step();
    phase     = 1;
    req_valid = 1'b0;
    req_tag   = TW'($urandom);
    flush     = lk_flush;
    step();
    phase   = 2;
    flush   = 1'b0;
    lru_way = PW'($urandom);
    for (int i = 0; i < hold; i++) begin
      step();
      phase = 3;
    end
    resp_ready = 1'b1;
    step();
    phase      = 0;
    resp_ready = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int av_before;
    model_init();
    do_reset(3);

    // Fill: four misses into ways 0..3 in order, one touch each.
    for (int i = 0; i < NW; i++) begin
      av_before = av_count;
      do_req(TW'((i + 1) * 16), 0, -1, 1'b0);
      check("fill_way", cap_way, i);
      check("fill_hit", cap_hit, 0);
      check("fill_evict", cap_evict, 0);
      check("fill_pulses", av_count, av_before + 1);
    end

    // Hit on 0x20 in way 1; way 0 stays least recently used.
    do_req(8'h20, 0, -1, 1'b0);
    check("hit20_hit", cap_hit, 1);
    check("hit20_way", cap_way, 1);
    check("hit20_lru", order[0], 0);

    // Full set, tracker says way 2: 0x55 evicts 0x30.
    do_req(8'h55, 0, 2, 1'b0);
    check("evict_hit", cap_hit, 0);
    check("evict_way", cap_way, 2);
    check("evict_flag", cap_evict, 1);
    check("evict_tag", cap_evict_tag, 8'h30);

    // 0x30 is gone: misses and evicts LRU way 0 (tag 0x10).
    do_req(8'h30, 0, -1, 1'b0);
    check("re30_hit", cap_hit, 0);
    check("re30_way", cap_way, 0);
    check("re30_evict_tag", cap_evict_tag, 8'h10);

    // Back-pressure for 5 cycles: one touch pulse only.
    av_before = av_count;
    do_req(8'h30, 5, -1, 1'b0);
    check("hold_hit", cap_hit, 1);
    check("hold_pulses", av_count, av_before + 1);

    // Flush in IDLE, then 0x10 lands in way 0 without eviction.
    do_flush();
    do_req(8'h10, 0, -1, 1'b0);
    check("flush_way", cap_way, 0);
    check("flush_evict", cap_evict, 0);
    // Flush during LOOKUP is ignored: 0x10 still hits afterwards.
    do_req(8'h99, 0, -1, 1'b1);
    check("lkflush_way", cap_way, 1);
    do_req(8'h10, 1, -1, 1'b0);
    check("lkflush_hit", cap_hit, 1);
    check("lkflush_hitway", cap_way, 0);

    // Reset in LOOKUP: no touch pulse, storage cleared.
    av_before = av_count;
    lru_way   = '0;
    req_valid = 1'b1;
    req_tag   = 8'h66;
    step();
    req_valid = 1'b0;
    #2;
    do_reset(2);
    check("rstlk_pulses", av_count, av_before);
    do_req(8'h77, 0, -1, 1'b0);
    check("rstlk_way", cap_way, 0);
    check("rstlk_hit", cap_hit, 0);
    check("rstlk_evict", cap_evict, 0);

    // Randomized traffic over a tag pool larger than the set.
    for (int n = 0; n < 300; n++) begin
      logic [TW-1:0] t;
      int hold, frc;
      bit lkf;
      if ($urandom_range(0, 9) == 0) do_flush();
      t    = TW'(16 * $urandom_range(1, 8));
      hold = $urandom_range(0, 3);
      frc  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NW - 1)) : -1;
      lkf  = ($urandom_range(0, 7) == 0);
      do_req(t, hold, frc, lkf);
    end

    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lru_way_allocator.md
LRU_WAY_ALLOCATOR -- requirements
Module: lru_way_allocator

Interface
REQ-001 SHALL have parameter NUM_WAYS, default 4, number of ways in the set (power of two, at least 2).
REQ-002 SHALL have parameter TAG_WIDTH, default 8, width of the tag stored per way.
REQ-003 SHALL derive localparam PTR_WIDTH = $clog2(NUM_WAYS).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  lookup request present.
REQ-007 req_ready  output  1  allocator can accept a request.
REQ-008 req_tag  input  TAG_WIDTH  tag to look up or allocate.
REQ-009 flush  input  1  invalidate all ways; honoured only in IDLE.
REQ-010 resp_valid  output  1  response present.
REQ-011 resp_ready  input  1  consumer accepts the response.
REQ-012 resp_hit  output  1  1 = tag found, 0 = tag allocated.
REQ-013 resp_way  output  PTR_WIDTH  way hit or allocated.
REQ-014 resp_evict  output  1  a valid tag was replaced.
REQ-015 resp_evict_tag  output  TAG_WIDTH  replaced tag; 0 when resp_evict=0.
REQ-016 access_way  output  PTR_WIDTH  way reported to the LRU tracker.
REQ-017 access_valid  output  1  one-cycle touch strobe to the LRU tracker.
REQ-018 lru_way  input  PTR_WIDTH  current LRU way from the tracker.

Function
REQ-019 SHALL hold per-way state tag[NUM_WAYS] and valid[NUM_WAYS].
REQ-020 SHALL implement FSM states IDLE, LOOKUP, RESP.
REQ-021 req_ready SHALL be 1 only in IDLE with flush=0.
REQ-022 IDLE: on req_valid&&req_ready, SHALL latch req_tag and go to LOOKUP.
REQ-023 IDLE: with flush=1, SHALL clear all valid bits that cycle, accept no request, and stay in IDLE.
REQ-024 LOOKUP: SHALL compare the latched tag against every way with valid=1; a hit SHALL occur on a match.
REQ-025 On a hit, SHALL set resp_hit=1, resp_way=matching way, and resp_evict=0.
REQ-026 On a miss with any invalid way, SHALL allocate the lowest-index invalid way with resp_evict=0.
REQ-027 On a miss with all ways valid, SHALL allocate the way given by lru_way sampled in the LOOKUP cycle, with resp_evict=1 and resp_evict_tag=old tag.
REQ-028 On allocation, SHALL write the tag and set valid on the LOOKUP-to-RESP edge.
REQ-029 SHALL drive access_valid=1 for exactly one cycle, the first RESP cycle, with access_way=resp_way; access_valid SHALL be 0 at all other times.
REQ-030 LOOKUP SHALL always advance to RESP after one cycle; request-to-resp_valid latency SHALL be 2 cycles.
REQ-031 RESP: resp_valid=1, and all resp_* outputs SHALL be held stable until resp_ready=1, then the FSM SHALL return to IDLE.
REQ-032 resp_ready=1 in the first RESP cycle SHALL complete the response in that cycle; the back-to-back request period SHALL be 3 cycles.
REQ-033 A tag stored in more than one way SHALL never occur; the hit search SHALL select the lowest-index match defensively.
REQ-034 flush outside IDLE SHALL be ignored; it is not queued.

Reset
REQ-035 reset_n=0 SHALL immediately force IDLE, clear all valid bits, zero all tags, and drive req_ready=0, resp_valid=0, resp_hit=0, resp_way=0, resp_evict=0, resp_evict_tag=0, access_way=0, and access_valid=0.
REQ-036 reset_n asserted mid-LOOKUP or mid-RESP SHALL abort the transaction with no access_valid pulse and no state write.
REQ-037 req_ready SHALL be 1 from the first clock edge after reset_n deasserts.

Verification
REQ-038 After reset, requests with tags 0x10, 0x20, 0x30, 0x40 -> misses allocated to ways 0,1,2,3 in order, resp_evict=0, one access_valid pulse each.
REQ-039 Request tag 0x20 -> resp_hit=1, resp_way=1, and access_way=1 pulsed; with a real LRU tracker, lru_way then remains 0.
REQ-040 Full set, lru_way=2, request tag 0x55 -> resp_hit=0, resp_way=2, resp_evict=1, resp_evict_tag=0x30; a following request for 0x30 misses.
REQ-041 Hold resp_ready=0 for 5 cycles -> resp_valid and resp_* stay stable, req_ready=0, and access_valid pulses exactly once.
REQ-042 flush in IDLE, then request tag 0x10 -> miss allocated to way 0 with resp_evict=0; flush during LOOKUP has no effect.
REQ-043 reset_n pulsed low during LOOKUP -> all outputs zero at once, no access_valid pulse, and the next request allocates way 0.
